// File: rtl/spatz_tcdm_bank_responder.sv
// TCDM bank responder: bridges one interconnect port to a single-port SRAM,
// executing atomics as a read followed by a one-cycle write-back.
package spatz_tcdm_bank_responder_pkg;
    typedef enum logic [3:0] {
        AMONone = 4'h0, AMOSwap = 4'h1, AMOAdd  = 4'h2, AMOAnd  = 4'h3,
        AMOOr   = 4'h4, AMOXor  = 4'h5, AMOMax  = 4'h6, AMOMaxu = 4'h7,
        AMOMin  = 4'h8, AMOMinu = 4'h9, AMOLR   = 4'hA, AMOSC   = 4'hB
    } amo_op_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        amo_op_e     amo;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        user;
    } tcdm_req_chan_t;

    typedef struct packed {
        logic           q_valid;
        tcdm_req_chan_t q;
    } tcdm_req_t;

    typedef struct packed {
        logic [31:0] data;
    } tcdm_rsp_chan_t;

    typedef struct packed {
        logic           q_ready;
        tcdm_rsp_chan_t p;
    } tcdm_rsp_t;
endpackage

module spatz_tcdm_bank_responder
    import spatz_tcdm_bank_responder_pkg::*;
#(
    parameter int unsigned MemAddrWidth          = 32,
    parameter int unsigned DataWidth             = 32,
    parameter int unsigned MemoryResponseLatency = 1,
    parameter type         mem_req_t             = tcdm_req_t,
    parameter type         mem_rsp_t             = tcdm_rsp_t
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  mem_req_t                  mem_req_i,
    output mem_rsp_t                  mem_rsp_o,
    output logic                      sram_req_o,
    output logic                      sram_we_o,
    output logic [MemAddrWidth-1:0]   sram_addr_o,
    output logic [DataWidth-1:0]      sram_wdata_o,
    output logic [DataWidth/8-1:0]    sram_be_o,
    input  logic [DataWidth-1:0]      sram_rdata_i,
    output logic                      dbg_state_o
);
    localparam int NumLanes  = int'(DataWidth / 32);
    localparam int LaneW     = (NumLanes > 1) ? $clog2(NumLanes) : 1;
    localparam int PipeDepth = int'(MemoryResponseLatency) - 1;

    typedef enum logic {Idle = 1'b0, AmoWrite = 1'b1} state_e;

    state_e                  state_q, state_d;
    logic [LaneW-1:0]        lane_d, lane_q;
    logic [31:0]             operand_d, operand_q;
    logic [MemAddrWidth-1:0] addr_q;
    amo_op_e                 op_q;
    logic                    is_rmw, handshake, q_ready;
    logic                    rsp_pending_d, rsp_pending_q;
    logic [31:0]             old_lane, new_lane;
    logic [DataWidth/8-1:0]  lane_be;
    logic [DataWidth-1:0]    rsp_data, rsp_out;
    logic                    unused_user;

    assign unused_user = ^mem_req_i.q.user;

    always_comb begin
        lane_d    = '0;
        operand_d = '0;
        old_lane  = '0;
        lane_be   = '0;
        for (int i = 0; i < NumLanes; i++) begin
            if (mem_req_i.q.strb[4*i +: 4] == 4'hF) lane_d = LaneW'(i);
        end
        for (int i = 0; i < NumLanes; i++) begin
            if (LaneW'(i) == lane_d) operand_d = mem_req_i.q.data[32*i +: 32];
            if (LaneW'(i) == lane_q) begin
                old_lane          = sram_rdata_i[32*i +: 32];
                lane_be[4*i +: 4] = 4'hF;
            end
        end
    end

    always_comb begin
        unique case (mem_req_i.q.amo)
            AMOSwap, AMOAdd, AMOAnd, AMOOr, AMOXor,
            AMOMax, AMOMaxu, AMOMin, AMOMinu: is_rmw = 1'b1;
            default:                          is_rmw = 1'b0;
        endcase
    end

    always_comb begin
        unique case (op_q)
            AMOSwap: new_lane = operand_q;
            AMOAdd:  new_lane = old_lane + operand_q;
            AMOAnd:  new_lane = old_lane & operand_q;
            AMOOr:   new_lane = old_lane | operand_q;
            AMOXor:  new_lane = old_lane ^ operand_q;
            AMOMax:  new_lane = ($signed(old_lane) > $signed(operand_q)) ? old_lane : operand_q;
            AMOMaxu: new_lane = (old_lane > operand_q) ? old_lane : operand_q;
            AMOMin:  new_lane = ($signed(old_lane) < $signed(operand_q)) ? old_lane : operand_q;
            AMOMinu: new_lane = (old_lane < operand_q) ? old_lane : operand_q;
            default: new_lane = old_lane;
        endcase
    end

    // q handshake: a request is taken on a rising clk_i edge where q_valid && q_ready;
    // q_ready never depends on q_valid, and the requester holds q stable until taken.
    always_comb begin
        state_d       = state_q;
        q_ready       = 1'b0;
        handshake     = 1'b0;
        rsp_pending_d = 1'b0;
        sram_req_o    = 1'b0;
        sram_we_o     = 1'b0;
        sram_addr_o   = mem_req_i.q.addr;
        sram_wdata_o  = mem_req_i.q.data;
        sram_be_o     = mem_req_i.q.strb;
        unique case (state_q)
            Idle: begin
                q_ready = 1'b1;
                if (mem_req_i.q_valid) begin
                    handshake  = 1'b1;
                    sram_req_o = 1'b1;
                    if (is_rmw) begin
                        rsp_pending_d = 1'b1;
                        state_d       = AmoWrite;
                    end else if (mem_req_i.q.amo == AMOSC) begin
                        sram_we_o = 1'b1;
                    end else if (mem_req_i.q.amo == AMONone && mem_req_i.q.write) begin
                        sram_we_o = 1'b1;
                    end else begin
                        rsp_pending_d = 1'b1;
                    end
                end
            end
            AmoWrite: begin
                sram_req_o   = 1'b1;
                sram_we_o    = 1'b1;
                sram_addr_o  = addr_q;
                sram_be_o    = lane_be;
                sram_wdata_o = {NumLanes{new_lane}};
                state_d      = Idle;
            end
            default: state_d = Idle;
        endcase
        // Keep the SRAM quiet and refuse requests for the whole reset window.
        if (!rst_ni) begin
            q_ready    = 1'b0;
            handshake  = 1'b0;
            sram_req_o = 1'b0;
            sram_we_o  = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= Idle;
            rsp_pending_q <= 1'b0;
            lane_q        <= '0;
            operand_q     <= '0;
            addr_q        <= '0;
            op_q          <= AMONone;
        end else begin
            state_q       <= state_d;
            rsp_pending_q <= rsp_pending_d;
            if (handshake && is_rmw) begin
                lane_q    <= lane_d;
                operand_q <= operand_d;
                addr_q    <= mem_req_i.q.addr;
                op_q      <= mem_req_i.q.amo;
            end
        end
    end

    // The AMO response is the old word, which is still on sram_rdata_i during AmoWrite.
    assign rsp_data = rsp_pending_q ? sram_rdata_i : '0;

    if (PipeDepth == 0) begin : gen_no_pipe
        assign rsp_out = rsp_data;
    end else begin : gen_pipe
        logic [DataWidth-1:0] pipe_q [PipeDepth];
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < PipeDepth; i++) pipe_q[i] <= '0;
            end else begin
                pipe_q[0] <= rsp_data;
                for (int i = 1; i < PipeDepth; i++) pipe_q[i] <= pipe_q[i-1];
            end
        end
        assign rsp_out = pipe_q[PipeDepth-1];
    end

    always_comb begin
        mem_rsp_o         = '0;
        mem_rsp_o.q_ready = q_ready;
        mem_rsp_o.p.data  = rsp_out;
    end

    assign dbg_state_o = (state_q == AmoWrite);
endmodule
